// File: rtl/seg_display_scanner.sv
// ============================================================================
// seg_display_scanner
//
// Shows one 32-bit CPU status word, chosen by display_op, as 8 hex digits on
// the board's multiplexed, active-low 7-segment display. Runs on the raw
// board clock.
//
// Each refresh frame lights the 8 digits in turn. The selected value and mode
// are captured into a shadow register on the frame boundary edge only. This
// keeps the digits from tearing when the inputs change mid-frame.
//
// Optional feature macro: SEG_DISPLAY_LEADING_ZERO_BLANK_EN
//   defined   : leading zero digits are blanked. Digit 0 is never blanked.
//               In mode 101 the address field (digits 7..5) and the data
//               field (digits 4..0) are blanked separately.
//   undefined : every digit is always drawn.
//
// Parameters
//   DIGIT_CYCLES      clocks each digit stays lit (>= 2)
//
// Ports
//   clk               board clock
//   rst_n             asynchronous active-low reset
//   display_op[2:0]   content select
//   ram_display_addr  RAM word address shown in mode 101
//   cycle_count       total CPU cycles
//   jump_count        unconditional branch count
//   branch_count      taken conditional branch count
//   pc                current PC
//   ram_data          RAM word at ram_display_addr
//   instr             current instruction
//   an[7:0]           digit enables, active-low, an[0] = rightmost digit
//   seg[6:0]          segments, active-low, seg[0]=a .. seg[6]=g
//   dp                decimal point, active-low
// ============================================================================
module seg_display_scanner #(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  display_op,
    input  logic [9:0]  ram_display_addr,
    input  logic [31:0] cycle_count,
    input  logic [31:0] jump_count,
    input  logic [31:0] branch_count,
    input  logic [31:0] pc,
    input  logic [31:0] ram_data,
    input  logic [31:0] instr,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int TICK_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_CYCLES - 1);

    localparam logic [2:0] OP_ADDR_DATA = 3'b101;
    localparam logic [2:0] DP_DIGIT     = 3'd5;

    logic [TICK_W-1:0] tick;
    logic [2:0]        idx;
    logic [31:0]       shadow;
    logic [2:0]        mode_q;

    logic [31:0]       sel_value;
    logic [3:0]        cur_nib;
    logic [6:0]        cur_glyph;
    logic              cur_blank;

    // ------------------------------------------------------------------
    // Content select
    // ------------------------------------------------------------------
    always_comb begin
        sel_value = 32'h0;
        case (display_op)
            3'b000:  sel_value = cycle_count;
            3'b001:  sel_value = jump_count;
            3'b010:  sel_value = branch_count;
            3'b011:  sel_value = pc;
            3'b100:  sel_value = ram_data;
            3'b101:  sel_value = {2'b00, ram_display_addr, ram_data[19:0]};
            3'b110:  sel_value = instr;
            default: sel_value = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit scan timer and frame snapshot
    // ------------------------------------------------------------------
    // The snapshot and the idx 7->0 wrap share one edge. Digit 0 of a new
    // frame is therefore always drawn from the new shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick   <= '0;
            idx    <= 3'd0;
            shadow <= 32'h0;
            mode_q <= 3'b000;
        end else if (tick == TICK_LAST) begin
            tick <= '0;
            idx  <= idx + 3'd1;
            if (idx == 3'd7) begin
                shadow <= sel_value;
                mode_q <= display_op;
            end
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hex font, active-low, bit order g..a
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        g = 7'h7F;
        case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    assign cur_nib   = shadow[{idx, 2'b00} +: 4];
    assign cur_glyph = hex_glyph(cur_nib);

    // ------------------------------------------------------------------
    // Leading-zero blanking
    // ------------------------------------------------------------------
`ifdef SEG_DISPLAY_LEADING_ZERO_BLANK_EN
    logic [7:0] nib_zero;
    logic [7:0] blank_vec;
    logic       zero_run;
    logic       field_split;

    assign field_split = (mode_q == OP_ADDR_DATA);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            nib_zero[i] = (shadow[4*i +: 4] == 4'h0);
        end
    end

    // Walk from the top digit down. zero_run stays set while every nibble
    // so far is zero. In split mode the run restarts at the top of the data
    // field. The lowest digit of each field is always drawn.
    always_comb begin
        blank_vec = 8'h00;
        zero_run  = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (field_split && (i == 4)) begin
                zero_run = 1'b1;
            end
            zero_run     = zero_run & nib_zero[i];
            blank_vec[i] = zero_run && (i != 0) && !(field_split && (i == 5));
        end
    end

    assign cur_blank = blank_vec[idx];
`else
    assign cur_blank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered display outputs, one clock behind idx/shadow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'h01 << idx);
            seg <= cur_blank ? 7'h7F : cur_glyph;
            dp  <= !((idx == DP_DIGIT) && (mode_q == OP_ADDR_DATA));
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner with DIGIT_CYCLES = 4.
// Stimulus pushes the expected {an, seg, dp} for each digit of each frame.
// The monitor pops one entry whenever a new digit enable appears. It also
// checks that every digit stays lit for exactly DIGIT_CYCLES clocks.
module tb_seg_display_scanner;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  display_op;
    logic [9:0]  ram_display_addr;
    logic [31:0] cycle_count, jump_count, branch_count, pc, ram_data, instr;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg_display_scanner #(.DIGIT_CYCLES(DC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .display_op       (display_op),
        .ram_display_addr (ram_display_addr),
        .cycle_count      (cycle_count),
        .jump_count       (jump_count),
        .branch_count     (branch_count),
        .pc               (pc),
        .ram_data         (ram_data),
        .instr            (instr),
        .an               (an),
        .seg              (seg),
        .dp               (dp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [15:0] exp_q[$];

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Push the expected display of digits 0..ndig-1 for a frame holding v.
    task automatic push_frame(input logic [31:0] v, input logic split, input int ndig);
        logic [7:0] blank;
        logic       run;
        logic [3:0] n;
        logic [6:0] s;
        logic [7:0] a;
        logic       d;
        blank = 8'h00;
        run   = 1'b1;
`ifdef SEG_DISPLAY_LEADING_ZERO_BLANK_EN
        for (int i = 7; i >= 0; i--) begin
            if (split && i == 4) run = 1'b1;
            run = run && (v[4*i +: 4] == 4'h0);
            blank[i] = run && (i != 0) && !(split && i == 5);
        end
`endif
        for (int k = 0; k < ndig; k++) begin
            n = v[4*k +: 4];
            s = blank[k] ? 7'h7F : font[n];
            a = ~(8'h01 << k);
            d = !(split && k == 5);
            exp_q.push_back({a, s, d});
        end
    endtask

    // Wait for an to change to value v. The wait is bounded.
    task automatic wait_an(input logic [7:0] v);
        bit other;
        bit done;
        other = (an != v);
        done  = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (an == v && other) done = 1'b1;
            if (an != v) other = 1'b1;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL wait_an: timeout waiting for an=%h, an=%h", v, an);
        end
    endtask

    // Monitor
    initial begin
        logic [7:0]  prev;
        logic [15:0] e;
        int          cnt;
        prev = 8'hFF;
        cnt  = 0;
        forever begin
            @(negedge clk);
            if (an != prev) begin
                if (prev != 8'hFF && an != 8'hFF) begin
                    checks++;
                    if (cnt != DC) begin
                        fails++;
                        $display("FAIL hold: an=%h lit %0d clocks, expected %0d", prev, cnt, DC);
                    end
                end
                if (an != 8'hFF) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected: an=%h seg=%b dp=%b with empty queue", an, seg, dp);
                    end else begin
                        e = exp_q.pop_front();
                        chk("an",  {24'h0, an},  {24'h0, e[15:8]});
                        chk("seg", {25'h0, seg}, {25'h0, e[7:1]});
                        chk("dp",  {31'h0, dp},  {31'h0, e[0]});
                    end
                end
                cnt  = 1;
                prev = an;
            end else begin
                cnt++;
            end
        end
    end

    // Stimulus
    initial begin
        display_op       = 3'b011;
        ram_display_addr = 10'h000;
        cycle_count      = 32'h1234_5678;
        jump_count       = 32'h0;
        branch_count     = 32'h0;
        pc               = 32'h0040_00AC;
        ram_data         = 32'h0;
        instr            = 32'h0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an",  {24'h0, an},  32'hFF);
        chk("rst_seg", {25'h0, seg}, 32'h7F);
        chk("rst_dp",  {31'h0, dp},  32'h1);

        push_frame(32'h0, 1'b0, 8);
        push_frame(32'h0040_00AC, 1'b0, 8);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_an",  {24'h0, an},  32'hFE);
        chk("first_seg", {25'h0, seg}, {25'h0, 7'b1000000});

        // Change the source mid-frame. The current frame keeps the PC.
        wait_an(8'h7F);
        wait_an(8'hF7);
        display_op = 3'b000;
        push_frame(32'h1234_5678, 1'b0, 8);

        wait_an(8'hF7);
        display_op       = 3'b101;
        ram_display_addr = 10'h3FF;
        ram_data         = 32'hFFFA_BCDE;
        push_frame(32'h3FFA_BCDE, 1'b1, 7);

        // Reset mid-frame during digit 6.
        wait_an(8'hFE);
        wait_an(8'hBF);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an",  {24'h0, an},  32'hFF);
        chk("mid_rst_seg", {25'h0, seg}, 32'h7F);
        chk("mid_rst_dp",  {31'h0, dp},  32'h1);
        repeat (2) @(negedge clk);
        chk("held_rst_an", {24'h0, an}, 32'hFF);

        push_frame(32'h0, 1'b0, 8);
        #2 rst_n = 1'b1;
        wait_an(8'h7F);
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Display-side consumer of the board switch decoder's `display_op[2:0]` and `ram_display_addr[9:0]` outputs. Selects one 32-bit CPU status word by `display_op` and shows it as 8 hex digits on the board's multiplexed, active-low 7-segment display. A snapshot is taken once per refresh frame so digits never tear. Runs on the raw board clock, not on the divided CPU clock.

## Interface

- `DIGIT_CYCLES`, default 100000: clocks each digit stays lit. Must be ≥ 2. At 100 MHz this gives 1 ms/digit and an 8 ms frame.
- `clk`  in  1  board clock, 100 MHz
- `rst_n`  in  1  reset, asynchronous and active-low
- `display_op`  in  3  content select from the switch decoder
- `ram_display_addr`  in  10  RAM word address from the switch decoder
- `cycle_count`  in  32  total CPU cycles
- `jump_count`  in  32  unconditional branch count
- `branch_count`  in  32  taken conditional branch count
- `pc`  in  32  current PC
- `ram_data`  in  32  RAM word at `ram_display_addr`
- `instr`  in  32  current instruction
- `an`  out  8  digit enables, active-low; `an[0]` is the rightmost digit
- `seg`  out  7  segments, active-low; `seg[0]`=a … `seg[6]`=g
- `dp`  out  1  decimal point, active-low

## Operation

- Select value by `display_op`:
  - 000 → `cycle_count`
  - 001 → `jump_count`
  - 010 → `branch_count`
  - 011 → `pc`
  - 100 → `ram_data`
  - 101 → {2'b00, `ram_display_addr`, `ram_data[19:0]`}
  - 110 → `instr`
  - 111 → 32'h0
- Mode 101 displays the address on digits 7..5 and the data on digits 4..0.
- Tick counter `tick` runs 0..DIGIT_CYCLES-1. Digit index `idx` is 3 bits.
- On the edge where `tick==DIGIT_CYCLES-1`:
  - `tick`←0
  - `idx`←`idx`+1; the 3-bit width makes it wrap 7→0
  - if `idx==7`, also `shadow`←selected value. This is the frame boundary.
- Otherwise `tick`←`tick`+1.
- Nibble shown on digit `idx` is `shadow[4*idx+3:4*idx]`.
- Hex font (g..a), values for nibble 0–F in order:
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- `an` is one-hot low at bit `idx`.
- `dp` is 0 only when `idx==5` and the latched mode is 101; otherwise 1. The mode is latched alongside `shadow`.
- Changes to `display_op`, `ram_display_addr` or the data inputs mid-frame are ignored until the next frame boundary.

## Timing

- Reset values, asynchronous and held while `rst_n`=0:
  - `an`=8'hFF, `seg`=7'h7F, `dp`=1
  - `tick`=0, `idx`=0, `shadow`=0, latched mode=000
- `an`, `seg` and `dp` are registered. They reflect `idx` and `shadow` with 1 clock of latency.
- The first edge after reset release drives `an`=8'hFE with the digit 0 glyph of `shadow`=0.
- Snapshot-to-display latency: a new `shadow` appears on digit 0 one clock after the frame-boundary edge.
- Display latency for an input change: worst case 8·DIGIT_CYCLES+1 clocks; best case 1 clock after a boundary.
- The snapshot update and the `idx` 7→0 wrap happen on the same edge. Digit 0 of the new frame is never shown from the old `shadow`.
- Reset asserted mid-frame forces all outputs blank immediately, with no clock needed. A full-length frame restarts at digit 0 after release.

## Configuration

- Macro: `SEG_DISPLAY_LEADING_ZERO_BLANK_EN`.
- Defined: a digit whose nibble and every higher nibble are zero is blanked (`seg`=7'h7F, its `an` bit still low). Digit 0 is never blanked, so value 0 shows a single "0".
  - In mode 101, blanking applies separately to the address field (digits 7..5, digit 5 never blanked) and the data field (digits 4..0, digit 0 never blanked).
- Undefined: all 8 digits are always drawn, including leading zeros.

## Test plan

- Reset with DIGIT_CYCLES=4: hold `rst_n`=0 → `an`=FF, `seg`=7F, `dp`=1. Release → after 1 clock `an`=FE, `seg`=1000000.
- `display_op`=011, `pc`=32'h0040_00AC before the first boundary → from the second frame, digits 7..0 show 0,0,4,0,0,0,A,C. Check `seg` for A=0001000 and C=1000110. `an` steps FE→FD→…→7F every 4 clocks.
- Change `display_op` from 011 to 000 (`cycle_count`=32'h12345678) at digit 3 → the rest of the frame still shows the PC. The next frame shows 1..8.
- `display_op`=101, `ram_display_addr`=10'h3FF, `ram_data`=32'hFFFA_BCDE → digits read 3,F,F,A,B,C,D,E. `dp`=0 only while `an`=8'hDF.
- With `SEG_DISPLAY_LEADING_ZERO_BLANK_EN`, `display_op`=001, `jump_count`=32'h0000_0005 → digits 7..1 show 7F, digit 0 shows 0010010. With `jump_count`=0, only digit 0 shows 1000000.
- Assert `rst_n` low at `idx`=6 mid-tick → outputs blank the same cycle. After release, digit 0 is held for a full 4 clocks and `shadow`=0.
